// File: rtl/std_seq_pkg.sv
// Shared definitions for the state-sequence monitor: the eight sequence codes
// and the lock FSM state encoding.
package std_seq_pkg;

  localparam logic [2:0] CODE_START = 3'b000;
  localparam logic [2:0] CODE_A     = 3'b010;
  localparam logic [2:0] CODE_B     = 3'b111;
  localparam logic [2:0] CODE_C     = 3'b100;
  localparam logic [2:0] CODE_D     = 3'b101;
  localparam logic [2:0] CODE_E     = 3'b001;
  localparam logic [2:0] CODE_F     = 3'b011;
  localparam logic [2:0] CODE_G     = 3'b110;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2,
    SLIP    = 2'd3
  } state_t;

endpackage

// File: rtl/std_code_decode.sv
// Combinational mapping from a 3-bit sequence code to its position (0..7)
// in the fixed eight-step sequence.
module std_code_decode
  import std_seq_pkg::*;
(
  input  logic [2:0] code,
  output logic [2:0] pos
);

  always_comb begin
    pos = 3'd0;
    case (code)
      CODE_START: pos = 3'd0;
      CODE_A:     pos = 3'd1;
      CODE_B:     pos = 3'd2;
      CODE_C:     pos = 3'd3;
      CODE_D:     pos = 3'd4;
      CODE_E:     pos = 3'd5;
      CODE_F:     pos = 3'd6;
      CODE_G:     pos = 3'd7;
      default:    pos = 3'd0;
    endcase
  end

endmodule

// File: rtl/std_seq_monitor.sv
// Checks that each valid code is the successor of the previous one, tracks
// lock status, and counts mismatches (while locked) and completed cycles.
module std_seq_monitor
  import std_seq_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_ERR = 2,
  parameter int ERR_W      = 8,
  parameter int CYC_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       code_in,
  input  logic             code_valid,
  output logic [2:0]       pos,
  output logic             pos_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             wrap_pulse,
  output logic [CYC_W-1:0] cycle_cnt
);

  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_ERR);

  logic [2:0]       dec_pos;
  logic [2:0]       prev_pos;
  logic [3:0]       good_cnt;
  logic [3:0]       bad_cnt;
  logic             correct;
  logic [ERR_W-1:0] err_next;
  state_t           state;

  std_code_decode u_decode (
    .code (code_in),
    .pos  (dec_pos)
  );

  assign correct  = (dec_pos == prev_pos + 3'd1);
  assign err_next = (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;

  // Every valid sample resyncs prev_pos, so a slip is charged once, not forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      pos        <= 3'd0;
      pos_valid  <= 1'b0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      wrap_pulse <= 1'b0;
      cycle_cnt  <= '0;
      prev_pos   <= 3'd0;
      good_cnt   <= 4'd0;
      bad_cnt    <= 4'd0;
    end else begin
      pos_valid  <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      if (code_valid) begin
        pos       <= dec_pos;
        pos_valid <= 1'b1;
        prev_pos  <= dec_pos;
        case (state)
          HUNT: begin
            good_cnt <= 4'd0;
            state    <= CONFIRM;
          end
          CONFIRM: begin
            if (correct) begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_cnt <= 4'd0;
            end
          end
          LOCKED: begin
            if (!correct) begin
              err_pulse <= 1'b1;
              err_cnt   <= err_next;
              bad_cnt   <= 4'd1;
              if (UNLOCK_N == 4'd1) begin
                state  <= HUNT;
                locked <= 1'b0;
              end else begin
                state <= SLIP;
              end
            end
          end
          SLIP: begin
            if (correct) begin
              bad_cnt <= 4'd0;
              state   <= LOCKED;
            end else begin
              err_pulse <= 1'b1;
              err_cnt   <= err_next;
              bad_cnt   <= bad_cnt + 4'd1;
              if (bad_cnt + 4'd1 >= UNLOCK_N) begin
                state  <= HUNT;
                locked <= 1'b0;
              end
            end
          end
          default: state <= HUNT;
        endcase
        if (correct && prev_pos == 3'd7 && (state == LOCKED || state == SLIP)) begin
          wrap_pulse <= 1'b1;
          cycle_cnt  <= cycle_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/std_seq_monitor.md
Name: std_seq_monitor

Overview:
- Downstream consumer of the 3-bit state-sequence generator output.
- Decodes each 3-bit code into its position in the fixed 8-step sequence and checks that every sample is the expected successor of the previous one.
- Keeps lock status, error and cycle counters, and a per-cycle position index for the display/status logic that follows it.

Parameters:
LOCK_CNT, 4, consecutive correct transitions needed to declare lock (1..15)
UNLOCK_ERR, 2, consecutive mismatches while locked that drop lock (1..15)
ERR_W, 8, width of saturating error counter
CYC_W, 16, width of wrapping full-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
code_in  in  3  sequence code from generator
code_valid  in  1  code_in is a sample this cycle
pos  out  3  decoded position of last valid sample
pos_valid  out  1  pos updated this cycle (1-cycle pulse)
locked  out  1  sequence lock established
err_pulse  out  1  1-cycle pulse per mismatching sample while locked
err_cnt  out  ERR_W  total mismatches while locked, saturates at all-ones
wrap_pulse  out  1  1-cycle pulse on a correct 7->0 transition while locked
cycle_cnt  out  CYC_W  count of wrap_pulse events, wraps modulo 2^CYC_W

Behaviour:
- Reset: state HUNT; pos=0, pos_valid=0, locked=0, err_pulse=0, err_cnt=0, wrap_pulse=0, cycle_cnt=0; internal prev_pos=0, good_cnt=0, bad_cnt=0.
- Reset asserted mid-operation clears everything in that same edge; locked is 0 from the next cycle.
- Decode is fixed: 000->0, 010->1, 111->2, 100->3, 101->4, 001->5, 011->6, 110->7. All 8 codes are legal.
- A sample is "correct" when its decoded position equals (prev_pos+1) mod 8. A repeated code counts as a mismatch.
- prev_pos is updated to the current position on every valid sample, so the checker resyncs to the latest sample.
- code_valid=0 means no compare, no state change, pulses low, all registers hold.
- All outputs are registered. The response to a sample appears on the cycle after the sample; latency is 1.
- FSM, evaluated only on valid samples:
  - HUNT: first sample loads prev_pos, good_cnt=0, go to CONFIRM.
  - CONFIRM:
    - Correct: good_cnt++. If good_cnt reaches LOCK_CNT, go to LOCKED and set locked=1.
    - Mismatch: good_cnt=0, stay in CONFIRM. No err_pulse; errors are only counted while locked.
  - LOCKED:
    - Correct: stay.
    - Mismatch: err_pulse, err_cnt++, bad_cnt=1. If UNLOCK_ERR=1, go to HUNT; otherwise go to SLIP.
  - SLIP (locked stays 1):
    - Correct: bad_cnt=0, go to LOCKED.
    - Mismatch: err_pulse, err_cnt++, bad_cnt++. If bad_cnt reaches UNLOCK_ERR, go to HUNT and set locked=0.
- wrap_pulse fires only for a correct 7->0 sample in LOCKED or SLIP. That sample also increments cycle_cnt in the same edge.
- err_cnt never wraps. At all-ones, err_pulse still fires but the counter holds.
- good_cnt and bad_cnt are 4 bits wide.

Decomposition:
- Package std_seq_pkg holds:
  - the 8 code constants (START=000, A=010, B=111, C=100, D=101, E=001, F=011, G=110);
  - the FSM state encoding (HUNT, CONFIRM, LOCKED, SLIP).
- Sub-module std_code_decode: combinational code->position mapping (3 in, 3 out). It is reused by later display blocks.

Test Plan:
1. Lock-in: rst, then START,A,B,C,D,... every cycle (LOCK_CNT=4) -> pos 0,1,2,3,4 one cycle late; locked=1 the cycle after D is sampled; err_cnt=0.
2. Wrap: locked, run F,G,START -> wrap_pulse high exactly one cycle after START is sampled; cycle_cnt 0->1; after 3 full cycles cycle_cnt=3.
3. Single slip: locked at B, feed B,B,C,D -> one err_pulse; err_cnt=1; locked stays 1; state returns to LOCKED after C.
4. Loss of lock: locked at B, feed E,A (UNLOCK_ERR=2) -> two err_pulses; err_cnt=2; locked=0 after A. Then 4 more correct transitions re-lock.
5. Valid gaps: sequence with code_valid=0 for 1-3 cycles between samples, and garbage on code_in during the gaps -> identical lock timing in sample count; no pulses during gaps.
6. Saturation/reset: ERR_W=2, force 6 mismatches while repeatedly re-locking -> err_cnt holds at 3. Assert rst while locked -> next cycle locked=0, err_cnt=0, cycle_cnt=0.
